writeback_arbiter: RTL and testbench

//  Collects results from N_SRC functional units (ALU, MUL, LOAD, ...) over valid/ready

---
 rtl/riscalar_pkg.sv | 30 +++
 rtl/writeback_arbiter_rr.sv | 50 +++++
 rtl/writeback_arbiter.sv | 160 ++++++++++++++++
 tb/tb_writeback_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscalar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscalar_pkg
// Description : Shared constants and types for the writeback path.
//               The register file and the writeback arbiter both use these:
//               XLEN     - datapath width
//               AW       - register address width
//               NUM_REGS - number of architectural registers (2**AW)
//               wb_req_t - one pending register write {addr, data}
//               rr_wrap_inc - round-robin pointer advance with wrap
// Revision    : 1.0  initial release
// ============================================================================
package riscalar_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 2 ** AW;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // Next round-robin position after index idx among n requesters.
    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin picker. Searches the request
//               vector starting at position i_ptr and moving upward with
//               wrap-around modulo N; the first set bit wins.
//   Ports     : i_req       [N]   request vector
//               i_ptr       [PW]  search start position (must be < N)
//               o_grant     [N]   one-hot grant, all zero when no request
//               o_grant_idx [PW]  index of the granted requester (0 if none)
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import riscalar_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_grant_idx
);

    // One extra bit so ptr + offset can exceed N before being folded back.
    localparam int c_cw = PW + 1;

    logic [c_cw-1:0] w_cand;
    logic            w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = {1'b0, i_ptr} + c_cw'(i);
            if (w_cand >= c_cw'(N)) begin
                w_cand = w_cand - c_cw'(N);
            end
            if (!w_found && i_req[w_cand[PW-1:0]]) begin
                w_found                   = 1'b1;
                o_grant[w_cand[PW-1:0]]   = 1'b1;
                o_grant_idx               = w_cand[PW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Collects results from N_SRC functional units over
//               valid/ready, keeps one result per source in a hold buffer,
//               grants one buffered result per cycle in round-robin order and
//               drives the register file write port from registered outputs.
//               Publishes a mask of registers with a write still in flight.
//   Ports     : clk_in            single clock, rising edge
//               rst_in            synchronous active-high reset
//               src_valid_in      [N_SRC]       source s presents a result
//               src_ready_out     [N_SRC]       source s can be accepted
//               src_addr_in       [N_SRC*AW]    dest reg of s at [s*AW +: AW]
//               src_data_in       [N_SRC*XLEN]  data of s at [s*XLEN +: XLEN]
//               we_out            register file write enable (1-cycle pulse)
//               wa_out            register file write address
//               wd_out            register file write data
//               pending_mask_out  [2**AW] bit r: write to r buffered/on port
//               busy_out          any hold buffer occupied
// Revision    : 1.0  initial release
// ============================================================================
module writeback_arbiter #(
    parameter int N_SRC = 3,
    parameter int XLEN  = riscalar_pkg::XLEN,
    parameter int AW    = riscalar_pkg::AW
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [N_SRC-1:0]      src_valid_in,
    output logic [N_SRC-1:0]      src_ready_out,
    input  logic [N_SRC*AW-1:0]   src_addr_in,
    input  logic [N_SRC*XLEN-1:0] src_data_in,
    output logic                  we_out,
    output logic [AW-1:0]         wa_out,
    output logic [XLEN-1:0]       wd_out,
    output logic [(2**AW)-1:0]    pending_mask_out,
    output logic                  busy_out
);

    import riscalar_pkg::*;

    localparam int c_pw       = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int c_num_regs = 2 ** AW;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] r_hold_valid;
    logic [AW-1:0]    r_hold_addr [N_SRC];
    logic [XLEN-1:0]  r_hold_data [N_SRC];
    logic [c_pw-1:0]  r_rr_ptr;
    logic             r_we;
    logic [AW-1:0]    r_wa;
    logic [XLEN-1:0]  r_wd;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [AW-1:0]         w_src_addr [N_SRC];
    logic [XLEN-1:0]       w_src_data [N_SRC];
    logic [N_SRC-1:0]      w_grant;
    logic [c_pw-1:0]       w_grant_idx;
    logic                  w_any_grant;
    logic [AW-1:0]         w_gnt_addr;
    logic [XLEN-1:0]       w_gnt_data;
    logic [N_SRC-1:0]      w_accept;
    logic [c_num_regs-1:0] w_pending;

    for (genvar s = 0; s < N_SRC; s++) begin : g_unpack
        assign w_src_addr[s] = src_addr_in[s*AW +: AW];
        assign w_src_data[s] = src_data_in[s*XLEN +: XLEN];
    end

    rr_arbiter #(
        .N  (N_SRC),
        .PW (c_pw)
    ) u_rr_arbiter (
        .i_req       (r_hold_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign w_any_grant = |w_grant;
    assign w_gnt_addr  = r_hold_addr[w_grant_idx];
    assign w_gnt_data  = r_hold_data[w_grant_idx];

    // A slot being drained this cycle can take a new result on the same
    // edge, which lets a continuously granted source stream one per cycle.
    assign src_ready_out = rst_in ? '0 : (~r_hold_valid | w_grant);
    assign w_accept      = src_valid_in & src_ready_out;

    // ------------------------------------------------------------------
    // Hold buffers: refill takes priority over the drain of a granted slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_hold_valid <= '0;
            for (int s = 0; s < N_SRC; s++) begin
                r_hold_addr[s] <= '0;
                r_hold_data[s] <= '0;
            end
        end else begin
            for (int s = 0; s < N_SRC; s++) begin
                if (w_accept[s]) begin
                    r_hold_valid[s] <= 1'b1;
                    r_hold_addr[s]  <= w_src_addr[s];
                    r_hold_data[s]  <= w_src_data[s];
                end else if (w_grant[s]) begin
                    r_hold_valid[s] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer and register file write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rr_ptr <= '0;
            r_we     <= 1'b0;
            r_wa     <= '0;
            r_wd     <= '0;
        end else if (w_any_grant) begin
            // x0 results are consumed like any other but never written.
            r_we     <= (w_gnt_addr != '0);
            r_wa     <= w_gnt_addr;
            r_wd     <= w_gnt_data;
            r_rr_ptr <= c_pw'(rr_wrap_inc(int'(w_grant_idx), N_SRC));
        end else begin
            r_we     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pending-write mask: buffered entries plus the write on the port.
    // x0 is hard-wired so it never shows as pending.
    // ------------------------------------------------------------------
    always_comb begin
        w_pending = '0;
        for (int s = 0; s < N_SRC; s++) begin
            if (r_hold_valid[s]) begin
                w_pending[r_hold_addr[s]] = 1'b1;
            end
        end
        if (r_we) begin
            w_pending[r_wa] = 1'b1;
        end
        w_pending[0] = 1'b0;
    end

    assign we_out           = r_we;
    assign wa_out           = r_wa;
    assign wd_out           = r_wd;
    assign pending_mask_out = w_pending;
    assign busy_out         = |r_hold_valid;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Self-checking bench for writeback_arbiter (N_SRC=3, XLEN=32,
//               AW=5). A behavioural model of the buffers/arbitration is
//               compared against the DUT at every falling edge; directed
//               sequences add literal expectations for the key scenarios,
//               followed by a randomized phase with occasional resets.
// Revision    : 1.0  initial release
// ============================================================================
module tb_writeback_arbiter;

    localparam int N  = 3;
    localparam int XL = 32;
    localparam int A  = 5;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [N-1:0]    src_valid_in;
    logic [N-1:0]    src_ready_out;
    logic [N*A-1:0]  src_addr_in;
    logic [N*XL-1:0] src_data_in;
    logic            we_out;
    logic [A-1:0]    wa_out;
    logic [XL-1:0]   wd_out;
    logic [31:0]     pending_mask_out;
    logic            busy_out;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    writeback_arbiter #(.N_SRC(N), .XLEN(XL), .AW(A)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .src_valid_in     (src_valid_in),
        .src_ready_out    (src_ready_out),
        .src_addr_in      (src_addr_in),
        .src_data_in      (src_data_in),
        .we_out           (we_out),
        .wa_out           (wa_out),
        .wd_out           (wd_out),
        .pending_mask_out (pending_mask_out),
        .busy_out         (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- behavioural model ----------------
    bit   [N-1:0]  mv  = '0;          // slot occupied
    logic [A-1:0]  ma [N] = '{default: '0};
    logic [XL-1:0] md [N] = '{default: '0};
    int            mptr = 0;
    logic          m_we = 1'b0;
    logic [A-1:0]  m_wa = '0;
    logic [XL-1:0] m_wd = '0;
    bit   [N-1:0]  m_hs = '0;         // handshake happened at last edge

    function automatic int rr_pick(input bit [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    int     mg;
    bit [N-1:0] mrdy;
    initial forever begin
        @(posedge clk_in);
        if (rst_in) begin
            mv = '0; mptr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_hs = '0;
        end else begin
            mg = rr_pick(mv, mptr);
            for (int s = 0; s < N; s++) mrdy[s] = !mv[s] || (mg == s);
            if (mg >= 0) begin
                m_we = (ma[mg] != 0);
                m_wa = ma[mg];
                m_wd = md[mg];
                mptr = (mg + 1) % N;
                mv[mg] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            for (int s = 0; s < N; s++) begin
                m_hs[s] = src_valid_in[s] && mrdy[s];
                if (m_hs[s]) begin
                    mv[s] = 1'b1;
                    ma[s] = src_addr_in[s*A +: A];
                    md[s] = src_data_in[s*XL +: XL];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    int         cg;
    bit [N-1:0] e_rdy;
    logic [31:0] e_mask;
    initial forever begin
        @(negedge clk_in);
        if (chk_en) begin
            cg = rr_pick(mv, mptr);
            for (int s = 0; s < N; s++) e_rdy[s] = !rst_in && (!mv[s] || cg == s);
            e_mask = '0;
            for (int s = 0; s < N; s++) if (mv[s]) e_mask[ma[s]] = 1'b1;
            if (m_we) e_mask[m_wa] = 1'b1;
            e_mask[0] = 1'b0;
            chk("m_we",    64'(we_out),           64'(m_we));
            chk("m_wa",    64'(wa_out),           64'(m_wa));
            chk("m_wd",    64'(wd_out),           64'(m_wd));
            chk("m_ready", 64'(src_ready_out),    64'(e_rdy));
            chk("m_mask",  64'(pending_mask_out), 64'(e_mask));
            chk("m_busy",  64'(busy_out),         64'(|mv));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic to_neg();
        @(negedge clk_in);
    endtask

    task automatic set_in(input bit [N-1:0] v,
                          input logic [A-1:0] a0, input logic [A-1:0] a1, input logic [A-1:0] a2,
                          input logic [XL-1:0] d0, input logic [XL-1:0] d1, input logic [XL-1:0] d2);
        #1;
        src_valid_in = v;
        src_addr_in  = {a2, a1, a0};
        src_data_in  = {d2, d1, d0};
    endtask

    task automatic idle();
        set_in(3'b000, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        #1; rst_in = 1'b1; src_valid_in = '0;
        to_neg();
        #1; rst_in = 1'b0;
    endtask

    logic [XL-1:0] rd;

    initial begin
        // ---- 1: reset with all sources valid ----
        rst_in = 1'b1;
        src_valid_in = '1;
        src_addr_in  = {5'd12, 5'd11, 5'd10};
        src_data_in  = {32'hC, 32'hB, 32'hA};
        for (int i = 0; i < 2; i++) begin
            to_neg();
            chk_en = 1'b1;
            chk("t1_ready", 64'(src_ready_out), 0);
            chk("t1_we",    64'(we_out), 0);
            chk("t1_mask",  64'(pending_mask_out), 0);
        end
        #1; rst_in = 1'b0;                 // valids still high
        to_neg(); idle();                  // all three accepted
        to_neg();
        chk("t1_first_we", 64'(we_out), 1);
        chk("t1_first_wa", 64'(wa_out), 10);
        chk("t1_first_wd", 64'(wd_out), 32'hA);
        to_neg(); to_neg(); to_neg();
        chk("t1_drained", 64'(busy_out), 0);

        // ---- 2: single source x5 ----
        set_in(3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0);
        to_neg(); idle();
        chk("t2_mask_buf", 64'(pending_mask_out[5]), 1);
        chk("t2_we_early", 64'(we_out), 0);
        to_neg();
        chk("t2_we", 64'(we_out), 1);
        chk("t2_wa", 64'(wa_out), 5);
        chk("t2_wd", 64'(wd_out), 32'hDEADBEEF);
        chk("t2_mask_port", 64'(pending_mask_out[5]), 1);
        to_neg();
        chk("t2_we_drop", 64'(we_out), 0);
        chk("t2_mask_clr", 64'(pending_mask_out[5]), 0);

        // ---- 3: contention from rr_ptr=0 ----
        pulse_reset();
        set_in(3'b111, 1, 2, 3, 1, 2, 3);
        to_neg(); idle();
        for (int k = 1; k <= 3; k++) begin
            to_neg();
            chk("t3_wa", 64'(wa_out), 64'(k));
            chk("t3_wd", 64'(wd_out), 64'(k));
        end
        set_in(3'b111, 4, 5, 6, 4, 5, 6);
        to_neg(); idle();
        for (int k = 4; k <= 6; k++) begin
            to_neg();
            chk("t3_wrap_wa", 64'(wa_out), 64'(k));
        end
        to_neg();

        // ---- 4: streaming src1 into x7 ----
        for (int i = 0; i < 12; i++) begin
            to_neg();
            if (i >= 1 && i <= 10) chk("t4_ready1", 64'(src_ready_out[1]), 1);
            if (i >= 2) begin
                chk("t4_we", 64'(we_out), 1);
                chk("t4_wa", 64'(wa_out), 7);
                chk("t4_wd", 64'(wd_out), 64'(i - 2));
            end
            rd = XL'(i);
            if (i < 10) set_in(3'b010, 0, 7, 0, 0, rd, 0);
            else        idle();
        end
        to_neg();

        // ---- 5: x0 writes are consumed silently ----
        pulse_reset();
        set_in(3'b100, 0, 0, 0, 0, 0, 32'h1234);
        to_neg(); idle();
        chk("t5_busy", 64'(busy_out), 1);
        chk("t5_mask0", 64'(pending_mask_out), 0);
        to_neg();
        chk("t5_we", 64'(we_out), 0);
        chk("t5_busy_clr", 64'(busy_out), 0);
        set_in(3'b001, 0, 0, 0, 32'h55, 0, 0);   // src0 x0 moves ptr to 1
        to_neg(); idle();
        to_neg();
        set_in(3'b111, 1, 2, 3, 1, 2, 3);
        to_neg(); idle();
        to_neg();
        chk("t5_ptr_adv", 64'(wa_out), 2);
        to_neg(); to_neg(); to_neg();

        // ---- 6: reset mid-stream ----
        set_in(3'b111, 8, 9, 10, 8, 9, 10);
        to_neg();
        chk("t6_busy", 64'(busy_out), 1);
        pulse_reset();
        chk("t6_rst_busy", 64'(busy_out), 0);
        chk("t6_rst_we", 64'(we_out), 0);
        chk("t6_rst_mask", 64'(pending_mask_out), 0);
        to_neg();
        chk("t6_after_we", 64'(we_out), 0);
        set_in(3'b111, 11, 12, 13, 11, 12, 13);
        to_neg(); idle();
        to_neg();
        chk("t6_ptr0", 64'(wa_out), 11);
        to_neg(); to_neg(); to_neg();

        // ---- randomized phase ----
        for (int c = 0; c < 4000; c++) begin
            to_neg();
            #1;
            rst_in = ($urandom_range(0, 249) == 0);
            for (int s = 0; s < N; s++) begin
                if (!(src_valid_in[s] && !m_hs[s])) begin
                    src_valid_in[s] = ($urandom_range(0, 99) < ((c < 2000) ? 40 : 90));
                    src_addr_in[s*A +: A] = ($urandom_range(0, 7) == 0) ? 5'd0
                                            : 5'($urandom_range(1, 31));
                    src_data_in[s*XL +: XL] = $urandom;
                end
            end
        end
        to_neg();
        #1; rst_in = 1'b0; src_valid_in = '0;
        for (int i = 0; i < 6; i++) to_neg();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
